top_k_ranker: RTL and testbench

TOP_K_RANKER -- requirements
Module: top_k_ranker

---
 rtl/ranker_pkg.sv | 19 +
 rtl/match_score.sv | 23 ++
 rtl/top_k_ranker.sv | 152 +++++++++++++++
 tb/tb_top_k_ranker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ranker_pkg.sv
// Shared types and constants for the top-K contestant ranker.
package ranker_pkg;

    // Round control states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccept = 2'd1,
        StDone   = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_Q = 4;
    localparam int unsigned DEF_ID_W  = 4;
    localparam int unsigned DEF_TOP_K = 3;

    // Accepted-contestant counter, saturating
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = 255;

endpackage

// File: rtl/match_score.sv
// Combinational score: number of answer bits that agree with the key.
module match_score #(
    parameter int unsigned NUM_Q = 4,
    parameter int unsigned SC_W  = $clog2(NUM_Q + 1)
) (
    input  logic [NUM_Q-1:0] i_ans,
    input  logic [NUM_Q-1:0] i_key,
    output logic [SC_W-1:0]  o_score
);

    logic [NUM_Q-1:0] w_match;

    assign w_match = ~(i_ans ^ i_key);

    // Popcount of matching bits
    always_comb begin
        o_score = '0;
        for (int unsigned i = 0; i < NUM_Q; i++) begin
            o_score = o_score + SC_W'(w_match[i]);
        end
    end

endmodule

// File: rtl/top_k_ranker.sv
// Streams scored contestants into a descending top-K list, one per cycle.
// Optional macro TOP_K_RANKER_TIE_LOWID_EN: equal scores rank by lower id
// instead of earlier arrival.
module top_k_ranker
    import ranker_pkg::*;
#(
    parameter int unsigned NUM_Q = DEF_NUM_Q,
    parameter int unsigned ID_W  = DEF_ID_W,
    parameter int unsigned TOP_K = DEF_TOP_K,
    parameter int unsigned SC_W  = $clog2(NUM_Q + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_Q-1:0]       key,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ID_W-1:0]        in_id,
    input  logic [NUM_Q-1:0]       in_ans,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOP_K*ID_W-1:0]  out_ids,
    output logic [TOP_K*SC_W-1:0]  out_scores,
    output logic [CNT_W-1:0]       out_count
);

    state_t           r_state;
    logic [NUM_Q-1:0] r_key;
    logic [CNT_W-1:0] r_count;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ID_W-1:0]  r_ids    [TOP_K];
    logic [SC_W-1:0]  r_scores [TOP_K];

    logic [SC_W-1:0]  w_score;
    logic [TOP_K-1:0] w_empty;
    logic [TOP_K-1:0] w_beats;
    logic [ID_W-1:0]  w_ids_nxt    [TOP_K];
    logic [SC_W-1:0]  w_scores_nxt [TOP_K];

    match_score #(
        .NUM_Q (NUM_Q),
        .SC_W  (SC_W)
    ) u_match_score (
        .i_ans   (in_ans),
        .i_key   (r_key),
        .o_score (w_score)
    );

    // Per-slot decision: does the incoming contestant outrank the occupant?
    // The list is kept sorted by the same rule, so w_beats is monotone.
    always_comb begin
        for (int unsigned i = 0; i < TOP_K; i++) begin
            w_empty[i] = (r_count <= CNT_W'(i));
`ifdef TOP_K_RANKER_TIE_LOWID_EN
            w_beats[i] = w_empty[i] || (w_score > r_scores[i]) ||
                         ((w_score == r_scores[i]) && (in_id < r_ids[i]));
`else
            w_beats[i] = w_empty[i] || (w_score > r_scores[i]);
`endif
        end
    end

    // Insertion: first beaten slot takes the newcomer, later beaten slots shift down
    always_comb begin
        w_ids_nxt[0]    = w_beats[0] ? in_id   : r_ids[0];
        w_scores_nxt[0] = w_beats[0] ? w_score : r_scores[0];
        for (int unsigned i = 1; i < TOP_K; i++) begin
            if (!w_beats[i]) begin
                w_ids_nxt[i]    = r_ids[i];
                w_scores_nxt[i] = r_scores[i];
            end else if (!w_beats[i-1]) begin
                w_ids_nxt[i]    = in_id;
                w_scores_nxt[i] = w_score;
            end else begin
                w_ids_nxt[i]    = r_ids[i-1];
                w_scores_nxt[i] = r_scores[i-1];
            end
        end
    end

    // Round FSM with registered handshake outputs and slot array
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_key       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            for (int unsigned i = 0; i < TOP_K; i++) begin
                r_ids[i]    <= '0;
                r_scores[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_key      <= key;
                        r_count    <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= StAccept;
                        for (int unsigned i = 0; i < TOP_K; i++) begin
                            r_ids[i]    <= '0;
                            r_scores[i] <= '0;
                        end
                    end
                end
                StAccept: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < TOP_K; i++) begin
                            r_ids[i]    <= w_ids_nxt[i];
                            r_scores[i] <= w_scores_nxt[i];
                        end
                        if (r_count != CNT_W'(CNT_MAX)) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (in_last) begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    // Flatten slots, place 1 in the least-significant slice
    always_comb begin
        for (int unsigned i = 0; i < TOP_K; i++) begin
            out_ids[i*ID_W +: ID_W]    = r_ids[i];
            out_scores[i*SC_W +: SC_W] = r_scores[i];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_count;

endmodule

// File: tb/tb_top_k_ranker.sv
// Directed self-checking bench for top_k_ranker (default parameters).
// Expected rankings follow TOP_K_RANKER_TIE_LOWID_EN when it is defined.
module tb_top_k_ranker;

    localparam int unsigned NUM_Q = 4;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned TOP_K = 3;
    localparam int unsigned SC_W  = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [NUM_Q-1:0]      key;
    logic                  in_valid;
    logic                  in_ready;
    logic [ID_W-1:0]       in_id;
    logic [NUM_Q-1:0]      in_ans;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [TOP_K*ID_W-1:0] out_ids;
    logic [TOP_K*SC_W-1:0] out_scores;
    logic [7:0]            out_count;

    int n_checks;
    int n_bad;

    logic [3:0] v_ids [7];
    logic [3:0] v_ans [7];

    top_k_ranker #(
        .NUM_Q (NUM_Q),
        .ID_W  (ID_W),
        .TOP_K (TOP_K),
        .SC_W  (SC_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_id      (in_id),
        .in_ans     (in_ans),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ids    (out_ids),
        .out_scores (out_scores),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [3:0] k);
        start = 1'b1;
        key   = k;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] id, input logic [3:0] ans, input logic last);
        int waited;
        in_valid = 1'b1;
        in_id    = id;
        in_ans   = ans;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) check_eq("send_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_table();
        for (int i = 0; i < 7; i++) begin
            send(v_ids[i], v_ans[i], (i == 6));
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, "_ov_low"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_rdy"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        logic [11:0] held_ids;
        logic [8:0]  held_sc;

        n_checks  = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        key       = '0;
        in_valid  = 1'b0;
        in_id     = '0;
        in_ans    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;

        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ids", 32'(out_ids), 32'd0);
        check_eq("rst_scores", 32'(out_scores), 32'd0);
        check_eq("rst_count", 32'(out_count), 32'd0);

        // in_valid in IDLE must not be accepted
        in_valid = 1'b1;
        in_id    = 4'd3;
        in_ans   = 4'b1111;
        step();
        in_valid = 1'b0;
        check_eq("idle_ignore_count", 32'(out_count), 32'd0);

        // Seven-contestant round, key 1010: scores 4,2,3,0,3,4,3
        v_ids = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        v_ans = '{4'b1010, 4'b0000, 4'b1011, 4'b0101, 4'b1110, 4'b1010, 4'b0010};
        do_start(4'b1010);
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        send_table();
        check_eq("r1_out_valid", 32'(out_valid), 32'd1);
        check_eq("r1_ids", 32'(out_ids), 32'h361);
        check_eq("r1_scores", 32'(out_scores), 32'h0E4);
        check_eq("r1_count", 32'(out_count), 32'd7);

        // Hold result while poking start/in_valid: nothing may change
        held_ids  = out_ids;
        held_sc   = out_scores;
        start     = 1'b1;
        key       = 4'b0101;
        in_valid  = 1'b1;
        in_id     = 4'd15;
        in_ans    = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_ids", 32'(out_ids), 32'(held_ids));
            check_eq("hold_scores", 32'(out_scores), 32'(held_sc));
            check_eq("hold_count", 32'(out_count), 32'd7);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        release_result("r1");
        check_eq("r1_retained_ids", 32'(out_ids), 32'h361);

        // Ids 1 and 6 swap arrival order
        v_ids = '{4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd7};
        do_start(4'b1010);
        send_table();
        check_eq("r2_out_valid", 32'(out_valid), 32'd1);
`ifdef TOP_K_RANKER_TIE_LOWID_EN
        check_eq("r2_ids", 32'(out_ids), 32'h361);
`else
        check_eq("r2_ids", 32'(out_ids), 32'h316);
`endif
        check_eq("r2_scores", 32'(out_scores), 32'h0E4);
        release_result("r2");

        // Two contestants: id 5 score 2, id 9 score 4
        do_start(4'b1010);
        send(4'd5, 4'b0000, 1'b0);
        send(4'd9, 4'b1010, 1'b1);
        check_eq("r3_ids", 32'(out_ids), 32'h059);
        check_eq("r3_scores", 32'(out_scores), 32'h014);
        check_eq("r3_count", 32'(out_count), 32'd2);
        release_result("r3");

        // Single-contestant round
        do_start(4'b0011);
        send(4'd12, 4'b0001, 1'b1);
        check_eq("r4_valid", 32'(out_valid), 32'd1);
        check_eq("r4_ids", 32'(out_ids), 32'h00C);
        check_eq("r4_scores", 32'(out_scores), 32'h003);
        check_eq("r4_count", 32'(out_count), 32'd1);
        release_result("r4");

        // Reset after third transfer of a round
        do_start(4'b1010);
        send(4'd1, 4'b1010, 1'b0);
        send(4'd2, 4'b1011, 1'b0);
        send(4'd3, 4'b0000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mrst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_ids", 32'(out_ids), 32'd0);
        check_eq("mrst_scores", 32'(out_scores), 32'd0);
        check_eq("mrst_count", 32'(out_count), 32'd0);

        // Fresh round after reset: no stale entries
        do_start(4'b1010);
        send(4'd5, 4'b0000, 1'b0);
        send(4'd9, 4'b1010, 1'b1);
        check_eq("r5_ids", 32'(out_ids), 32'h059);
        check_eq("r5_scores", 32'(out_scores), 32'h014);
        check_eq("r5_count", 32'(out_count), 32'd2);
        release_result("r5");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
